// File: rtl/packet_tx_framer.sv
// Response packet serializer: OPCODE, RESERVED, LEN_LSB, LEN_MSB, then payload bytes LSB-first.
// LEN counts the whole frame including the four header bytes.
module packet_tx_framer #(
  parameter int DATA_BYTES_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    opcode_i,
  input  logic [8*DATA_BYTES_MAX-1:0]   result_i,
  input  logic [3:0]                    result_bytes_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          busy_o,
  output logic [2:0]                    state_o
);

  localparam int IDX_W = (DATA_BYTES_MAX > 1) ? $clog2(DATA_BYTES_MAX) : 1;
  localparam logic [3:0] N_MAX = 4'(DATA_BYTES_MAX);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPC  = 3'd1;
  localparam logic [2:0] ST_RSV  = 3'd2;
  localparam logic [2:0] ST_LSB  = 3'd3;
  localparam logic [2:0] ST_MSB  = 3'd4;
  localparam logic [2:0] ST_PAY  = 3'd5;

  logic [2:0]                  state_r, state_s;
  logic [7:0]                  opcode_r, opcode_s;
  logic [8*DATA_BYTES_MAX-1:0] result_r, result_s;
  logic [3:0]                  n_r, n_s;
  logic [IDX_W-1:0]            idx_r, idx_s;
  logic                        ready_r, valid_r, busy_r;
  logic [7:0]                  data_r;
  logic                        accept_s, xfer_s;

  function automatic logic [3:0] clamp_len(input logic [3:0] cnt);
    if (cnt > N_MAX) begin
      clamp_len = N_MAX;
    end else begin
      clamp_len = cnt;
    end
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic [2:0]                  st,
    input logic [7:0]                  opc,
    input logic [8*DATA_BYTES_MAX-1:0] res,
    input logic [3:0]                  n,
    input logic [IDX_W-1:0]            idx
  );
    logic [15:0] len;
    len = {12'h000, n} + 16'd4;
    case (st)
      ST_OPC:  frame_byte = opc;
      ST_RSV:  frame_byte = 8'h00;
      ST_LSB:  frame_byte = len[7:0];
      ST_MSB:  frame_byte = len[15:8];
      ST_PAY:  frame_byte = res[{idx, 3'b000} +: 8];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  assign accept_s = valid_i && ready_r;
  assign xfer_s   = valid_r && ready_i;

  // Next-state and latched-word update; a stalled byte leaves every register unchanged.
  always_comb begin
    state_s  = state_r;
    opcode_s = opcode_r;
    result_s = result_r;
    n_s      = n_r;
    idx_s    = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          opcode_s = opcode_i;
          result_s = result_i;
          n_s      = clamp_len(result_bytes_i);
          idx_s    = '0;
          state_s  = ST_OPC;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_OPC: begin
        if (xfer_s) begin
          state_s = ST_RSV;
        end else begin
          state_s = ST_OPC;
        end
      end
      ST_RSV: begin
        if (xfer_s) begin
          state_s = ST_LSB;
        end else begin
          state_s = ST_RSV;
        end
      end
      ST_LSB: begin
        if (xfer_s) begin
          state_s = ST_MSB;
        end else begin
          state_s = ST_LSB;
        end
      end
      ST_MSB: begin
        if (xfer_s) begin
          state_s = (n_r != 4'd0) ? ST_PAY : ST_IDLE;
        end else begin
          state_s = ST_MSB;
        end
      end
      ST_PAY: begin
        // Exit on the last payload byte so the index never wraps.
        if (xfer_s) begin
          if (4'(idx_r) == (n_r - 4'd1)) begin
            state_s = ST_IDLE;
          end else begin
            idx_s   = idx_r + IDX_W'(1'b1);
            state_s = ST_PAY;
          end
        end else begin
          state_s = ST_PAY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, latched word and Moore outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      opcode_r <= 8'h00;
      result_r <= '0;
      n_r      <= 4'd0;
      idx_r    <= '0;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      data_r   <= 8'h00;
    end else begin
      state_r  <= state_s;
      opcode_r <= opcode_s;
      result_r <= result_s;
      n_r      <= n_s;
      idx_r    <= idx_s;
      ready_r  <= (state_s == ST_IDLE);
      valid_r  <= (state_s != ST_IDLE);
      busy_r   <= (state_s != ST_IDLE);
      data_r   <= (state_s == ST_IDLE) ? 8'h00
                  : frame_byte(state_s, opcode_s, result_s, n_s, idx_s);
    end
  end

  assign ready_o = ready_r;
  assign valid_o = valid_r;
  assign busy_o  = busy_r;
  assign data_o  = data_r;
  assign state_o = state_r;

endmodule

// File: tb/tb_packet_tx_framer.sv
// Scoreboard bench for packet_tx_framer: expected frames are built from the packet format
// when a word is accepted, and a negedge monitor pops and compares every transferred byte.
module tb_packet_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  opcode_i = 8'h00;
  logic [63:0] result_i = 64'h0;
  logic [3:0]  result_bytes_i = 4'd0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        busy_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  packet_tx_framer #(.DATA_BYTES_MAX(8)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .result_i(result_i),
    .result_bytes_i(result_bytes_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
    .state_o(state_o)
  );

  logic [10:0] sb[$];  // {expected state code, expected byte}
  int vectors = 0;
  int miscompares = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: header then min(nb,8) payload bytes, LEN = payload + 4.
  task automatic push_packet(input logic [7:0] op, input logic [63:0] res, input int nb);
    int n;
    int len;
    n = (nb > 8) ? 8 : nb;
    len = n + 4;
    sb.push_back({3'd1, op});
    sb.push_back({3'd2, 8'h00});
    sb.push_back({3'd3, 8'(len % 256)});
    sb.push_back({3'd4, 8'(len / 256)});
    for (int k = 0; k < n; k++) sb.push_back({3'd5, 8'(res >> (8 * k))});
  endtask

  // ready_i driver: constant 1 or random, changed just after each rising edge.
  always begin
    @(posedge clk);
    #2;
    ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops and compares each transferred byte, checks stall hold and idle zero.
  logic [7:0] prev_data = 8'h00;
  logic prev_stall = 1'b0;
  logic [10:0] exp_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("busy_vs_valid", 64'(busy_o), 64'(valid_o));
      if (!valid_o) check("idle_data_zero", 64'(data_o), 64'h0);
      if (prev_stall) check("stall_hold", 64'(data_o), 64'(prev_data));
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h expected no byte", data_o);
        end else begin
          exp_e = sb.pop_front();
          check("byte", 64'(data_o), 64'(exp_e[7:0]));
          check("state", 64'(state_o), 64'(exp_e[10:8]));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_data = data_o;
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready_o && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_timeout", 64'(ready_o), 64'h1);
  endtask

  // Issues one word; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] op, input logic [63:0] res, input logic [3:0] nb);
    @(posedge clk);
    #2;
    valid_i = 1'b1;
    opcode_i = op;
    result_i = res;
    result_bytes_i = nb;
    wait_ready();
    push_packet(op, res, int'(nb));
    @(posedge clk);
    #2;
    valid_i = 1'b0;
    opcode_i = 8'($urandom);
    result_i = {$urandom, $urandom};
    result_bytes_i = 4'($urandom);
    @(negedge clk);
    check("opc_latency_valid", 64'(valid_o), 64'h1);
    check("opc_latency_data", 64'(data_o), 64'(op));
  endtask

  // With ready_i fixed at 1: valid for exactly 4+n cycles, then ready_o back.
  task automatic expect_burst(input int n);
    int cnt;
    cnt = 0;
    while (valid_o && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("burst_len", 64'(cnt), 64'(n + 4));
    check("ready_after", 64'(ready_o), 64'h1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy_o || sb.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    int pays;
    int guard;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'h0);
    check("rst_valid", 64'(valid_o), 64'h0);
    check("rst_data", 64'(data_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_state", 64'(state_o), 64'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed frames with ready_i held high
    send(8'h01, 64'h00000000_DEADBEEF, 4'd4);
    expect_burst(4);
    wait_idle();
    send(8'hEC, 64'h1122334455667788, 4'd0);
    expect_burst(0);
    wait_idle();
    send(8'h77, 64'hA1A2A3A4A5A6A7A8, 4'd15);
    expect_burst(8);
    wait_idle();

    // Full payload under random backpressure
    rand_ready = 1'b1;
    send(8'h12, 64'h0807060504030201, 4'd8);
    wait_idle();

    // Reset during the third payload byte drops the frame
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    send(8'h5A, 64'hF0E0D0C0B0A09080, 4'd8);
    pays = 0;
    guard = 0;
    while (pays < 3 && guard < 100) begin
      if (state_o == 3'd5) pays++;
      if (pays < 3) @(negedge clk);
      guard++;
    end
    check("reach_pay2", 64'(pays), 64'h3);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_valid", 64'(valid_o), 64'h0);
    check("midrst_data", 64'(data_o), 64'h0);
    check("midrst_busy", 64'(busy_o), 64'h0);
    check("midrst_ready", 64'(ready_o), 64'h0);
    check("midrst_state", 64'(state_o), 64'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    send(8'h3C, 64'h0000000000CAFE01, 4'd3);
    expect_burst(3);
    wait_idle();

    // valid_i held high across two words: exactly one idle cycle between frames
    @(posedge clk);
    #2;
    valid_i = 1'b1;
    opcode_i = 8'hA1;
    result_i = 64'h000000000000BEEF;
    result_bytes_i = 4'd2;
    wait_ready();
    push_packet(8'hA1, 64'h000000000000BEEF, 2);
    @(posedge clk);
    #2;
    opcode_i = 8'hB2;
    result_i = 64'h0000000000123456;
    result_bytes_i = 4'd3;
    push_packet(8'hB2, 64'h0000000000123456, 3);
    guard = 0;
    @(negedge clk);
    while (valid_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    gap = 0;
    while (!valid_o && gap < 50) begin
      check("gap_ready", 64'(ready_o), 64'h1);
      gap++;
      @(negedge clk);
    end
    check("b2b_gap", 64'(gap), 64'h1);
    @(posedge clk);
    #2;
    valid_i = 1'b0;
    wait_idle();

    // Randomized words under random backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      send(8'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
